// File: rtl/prbs4_checker.sv
// PRBS-4 (x^4+x^3+1, XNOR form) receive checker: seeds a shadow generator from
// the incoming stream, then flywheels it and counts mismatches against it.
module prbs4_checker #(
    parameter int ERR_W       = 8,
    parameter int LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bit_in,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       data_out
);

    typedef enum logic {SEED, CHECK} state_t;

    localparam logic [3:0]       LOSS_LAST = 4'(LOSS_THRESH - 1);
    localparam logic [ERR_W-1:0] CNT_ONE   = ERR_W'(1);

    state_t     state, state_nxt;
    logic [4:1] sreg;
    logic [2:0] fill;
    logic [3:0] consec;

    logic expected, mismatch, seed_done, seed_lockup, chk_err, loss;

    assign expected    = sreg[3] ~^ sreg[4];
    assign mismatch    = bit_in != expected;
    assign seed_done   = en && (state == SEED) && (fill == 3'd3);
    // all-ones is the XNOR generator's stuck state; never lock onto it
    assign seed_lockup = {sreg[3:1], bit_in} == 4'b1111;
    assign chk_err     = en && (state == CHECK) && mismatch;
    assign loss        = chk_err && (consec == LOSS_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= SEED;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEED:    if (seed_done && !seed_lockup) state_nxt = CHECK;
            CHECK:   if (loss)                      state_nxt = SEED;
            default: state_nxt = SEED;
        endcase
    end

    always_comb begin
        locked   = (state == CHECK);
        data_out = sreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg      <= '0;
            fill      <= '0;
            consec    <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= chk_err;
            if (en) begin
                if (state == SEED) begin
                    sreg   <= {sreg[3:1], bit_in};
                    fill   <= (fill == 3'd3) ? 3'd0 : fill + 3'd1;
                    consec <= '0;
                end else begin
                    // flywheel: the reference never takes the received bit
                    sreg <= {sreg[3:1], expected};
                    fill <= '0;
                    if (!mismatch || loss) consec <= '0;
                    else                   consec <= consec + 4'd1;
                end
            end
            if (err_clr)
                err_count <= '0;
            else if (chk_err && (err_count != {ERR_W{1'b1}}))
                err_count <= err_count + CNT_ONE;
        end
    end

endmodule
